// File: rtl/readout_pkg.sv
// Shared types and parameter defaults for the column-drain readout sequencer.
package readout_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FREEZE,
    READ,
    SHIFT,
    DONE
  } seq_state_t;

  localparam int unsigned WORD_BITS_DEF    = 27;
  localparam int unsigned FREEZE_SETUP_DEF = 4;
  localparam int unsigned CNT_W_DEF        = 8;
  localparam int unsigned WDOG_CYCLES_DEF  = 4096;

endpackage

// File: rtl/seq_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero.
module seq_timer #(
  parameter int unsigned W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/readout_sequencer.sv
// Column-drain readout sequencer: freeze columns, then one Read strobe per hit word.
// Optional frame watchdog enabled by defining READOUT_WATCHDOG_EN.
module readout_sequencer
  import readout_pkg::*;
#(
  parameter int unsigned WORD_BITS    = WORD_BITS_DEF,
  parameter int unsigned FREEZE_SETUP = FREEZE_SETUP_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF,
  parameter int unsigned WDOG_CYCLES  = WDOG_CYCLES_DEF
) (
  input  logic             ClkOut,
  input  logic             Reset,
  input  logic             EnReadout,
  input  logic             TokenIn,
  output logic             Freeze,
  output logic             Read,
  output logic             Busy,
  output logic             FrameDone,
  output logic [CNT_W-1:0] HitCount,
  output logic             Timeout
);

  localparam int unsigned MAXV = (WORD_BITS > FREEZE_SETUP) ? WORD_BITS : FREEZE_SETUP;
  localparam int unsigned TW   = $clog2(MAXV + 1);

  if (WORD_BITS < 2) begin : g_chk_word_bits
    $error("readout_sequencer: WORD_BITS must be >= 2");
  end
  if (FREEZE_SETUP < 1) begin : g_chk_freeze_setup
    $error("readout_sequencer: FREEZE_SETUP must be >= 1");
  end
  if (WDOG_CYCLES < 2) begin : g_chk_wdog
    $error("readout_sequencer: WDOG_CYCLES must be >= 2");
  end

  seq_state_t       r_state;
  seq_state_t       w_next;
  logic [CNT_W-1:0] r_hits;
  logic             w_enter_freeze;
  logic             w_tmr_load;
  logic [TW-1:0]    w_tmr_val;
  logic             w_tc;
  logic             w_abort;

  assign w_enter_freeze = (r_state == IDLE) && EnReadout && TokenIn;

  // Timer is loaded one short of the phase length so terminal count lands
  // on the last cycle of FREEZE / SHIFT; Read edges are WORD_BITS apart.
  assign w_tmr_load = w_enter_freeze || (r_state == READ);
  assign w_tmr_val  = w_enter_freeze ? TW'(FREEZE_SETUP - 1) : TW'(WORD_BITS - 2);

  seq_timer #(
    .W (TW)
  ) u_timer (
    .i_clk      (ClkOut),
    .i_rst      (Reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tc)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (w_enter_freeze) w_next = FREEZE;
      FREEZE: begin
        if (w_abort)   w_next = DONE;
        else if (w_tc) w_next = TokenIn ? READ : DONE;
      end
      READ:    w_next = SHIFT;
      SHIFT: begin
        if (w_abort)   w_next = DONE;
        else if (w_tc) w_next = (TokenIn && EnReadout) ? READ : DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ClkOut or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge ClkOut or posedge Reset) begin
    if (Reset) begin
      r_hits <= '0;
    end else if (w_enter_freeze) begin
      r_hits <= '0;
    end else if ((r_state == READ) && (r_hits != '1)) begin
      r_hits <= r_hits + 1'b1;
    end
  end

`ifdef READOUT_WATCHDOG_EN
  localparam int unsigned FW = $clog2(WDOG_CYCLES + 1);

  logic [FW-1:0] r_frame_cnt;
  logic          r_timeout;

  // Counter reads k during the k-th cycle of the frame, so the abort
  // decision at WDOG_CYCLES-1 puts DONE on frame cycle WDOG_CYCLES.
  always_ff @(posedge ClkOut or posedge Reset) begin
    if (Reset) begin
      r_frame_cnt <= '0;
    end else if (w_enter_freeze) begin
      r_frame_cnt <= FW'(1);
    end else if ((r_state != IDLE) && (r_frame_cnt < FW'(WDOG_CYCLES))) begin
      r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  assign w_abort = ((r_state == FREEZE) || (r_state == SHIFT)) &&
                   (r_frame_cnt >= FW'(WDOG_CYCLES - 1));

  always_ff @(posedge ClkOut or posedge Reset) begin
    if (Reset) begin
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_abort;
    end
  end

  assign Timeout = r_timeout;
`else
  assign w_abort = 1'b0;
  assign Timeout = 1'b0;
`endif

  assign Freeze    = (r_state == FREEZE) || (r_state == READ) || (r_state == SHIFT);
  assign Read      = (r_state == READ);
  assign Busy      = (r_state != IDLE);
  assign FrameDone = (r_state == DONE);
  assign HitCount  = r_hits;

endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a scoreboard of expected Read/FrameDone cycles.
module tb_readout_sequencer;

  logic       ClkOut = 1'b0;
  logic       Reset;
  logic       EnReadout;
  logic       TokenIn;
  logic       Freeze;
  logic       Read;
  logic       Busy;
  logic       FrameDone;
  logic [7:0] HitCount;
  logic       Timeout;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned frames_done = 0;

  typedef struct {
    int unsigned cyc;
    int unsigned hits;
    logic        tmo;
  } done_t;

  int unsigned exp_read_q[$];
  done_t       exp_done_q[$];

  readout_sequencer #(
    .WORD_BITS    (27),
    .FREEZE_SETUP (4),
    .CNT_W        (8),
    .WDOG_CYCLES  (100)
  ) dut (
    .ClkOut    (ClkOut),
    .Reset     (Reset),
    .EnReadout (EnReadout),
    .TokenIn   (TokenIn),
    .Freeze    (Freeze),
    .Read      (Read),
    .Busy      (Busy),
    .FrameDone (FrameDone),
    .HitCount  (HitCount),
    .Timeout   (Timeout)
  );

  always #5 ClkOut = ~ClkOut;

  always @(posedge ClkOut) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic goto(input int unsigned c);
    while (cyc < c) begin
      @(posedge ClkOut);
      #1;
    end
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    int unsigned n = 0;
    while ((frames_done < target) && (n < budget)) begin
      @(posedge ClkOut);
      #1;
      n++;
    end
    chk("frame_end_timely", frames_done >= target, 1);
  endtask

  task automatic push_done(input int unsigned c, input int unsigned h, input logic t);
    done_t d;
    d.cyc  = c;
    d.hits = h;
    d.tmo  = t;
    exp_done_q.push_back(d);
  endtask

  // Scoreboard consumer: every Read / FrameDone must match the next expected entry.
  always @(negedge ClkOut) begin
    if (Read === 1'b1) begin
      checks++;
      assert (exp_read_q.size() != 0) else begin
        errors++;
        $error("FAIL read_unexpected observed_cycle=%0d expected=none", cyc);
      end
      if (exp_read_q.size() != 0) begin
        int unsigned e;
        e = exp_read_q.pop_front();
        checks++;
        assert (cyc === e) else begin
          errors++;
          $error("FAIL read_cycle observed=%0d expected=%0d", cyc, e);
        end
        checks++;
        assert (Freeze === 1'b1) else begin
          errors++;
          $error("FAIL freeze_during_read observed=%b expected=1", Freeze);
        end
      end
    end
    if (FrameDone === 1'b1) begin
      frames_done++;
      checks++;
      assert (exp_done_q.size() != 0) else begin
        errors++;
        $error("FAIL done_unexpected observed_cycle=%0d expected=none", cyc);
      end
      if (exp_done_q.size() != 0) begin
        done_t d;
        d = exp_done_q.pop_front();
        checks++;
        assert (cyc === d.cyc) else begin
          errors++;
          $error("FAIL done_cycle observed=%0d expected=%0d", cyc, d.cyc);
        end
        checks++;
        assert (HitCount === 8'(d.hits)) else begin
          errors++;
          $error("FAIL done_hitcount observed=%0d expected=%0d", HitCount, d.hits);
        end
        checks++;
        assert (Timeout === d.tmo) else begin
          errors++;
          $error("FAIL done_timeout observed=%b expected=%b", Timeout, d.tmo);
        end
        checks++;
        assert (Freeze === 1'b0) else begin
          errors++;
          $error("FAIL done_freeze observed=%b expected=0", Freeze);
        end
      end
    end
  end

  initial begin
    int unsigned t0;

    Reset     = 1'b1;
    EnReadout = 1'b1;
    TokenIn   = 1'b0;
    repeat (3) @(posedge ClkOut);
    #1;
    Reset = 1'b0;

    // Idle after reset, no token for 100 cycles
    goto(cyc + 100);
    chk("idle_freeze", Freeze, 0);
    chk("idle_read", Read, 0);
    chk("idle_busy", Busy, 0);
    chk("idle_hitcount", HitCount, 0);
    chk("idle_timeout", Timeout, 0);

    // Token with readout disabled must not start a frame
    EnReadout = 1'b0;
    TokenIn   = 1'b1;
    goto(cyc + 10);
    chk("disabled_busy", Busy, 0);
    TokenIn   = 1'b0;
    EnReadout = 1'b1;
    goto(cyc + 2);

    // Three hits
    t0 = cyc;
    TokenIn = 1'b1;
    exp_read_q.push_back(t0 + 5);
    exp_read_q.push_back(t0 + 32);
    exp_read_q.push_back(t0 + 59);
    push_done(t0 + 86, 3, 1'b0);
    goto(t0 + 1);
    chk("t2_freeze_entry", Freeze, 1);
    chk("t2_busy_entry", Busy, 1);
    chk("t2_hitcount_entry", HitCount, 0);
    goto(t0 + 59);
    TokenIn = 1'b0;
    wait_frames(1, 200);
    goto(cyc + 3);
    chk("t2_hitcount_hold", HitCount, 3);
    chk("t2_busy_after", Busy, 0);

    // Spurious token: empty frame, HitCount cleared from previous frame
    t0 = cyc;
    TokenIn = 1'b1;
    push_done(t0 + 5, 0, 1'b0);
    goto(t0 + 1);
    TokenIn = 1'b0;
    chk("t3_freeze", Freeze, 1);
    chk("t3_hitcount_cleared", HitCount, 0);
    wait_frames(2, 50);
    goto(cyc + 2);

    // Enable drop after the second Read lets the word finish, then ends the frame
    t0 = cyc;
    TokenIn = 1'b1;
    exp_read_q.push_back(t0 + 5);
    exp_read_q.push_back(t0 + 32);
    push_done(t0 + 59, 2, 1'b0);
    goto(t0 + 35);
    EnReadout = 1'b0;
    wait_frames(3, 100);
    chk("t4_no_restart", Busy, 0);
    TokenIn = 1'b0;
    goto(cyc + 1);
    EnReadout = 1'b1;
    goto(cyc + 2);

    // Asynchronous reset in the middle of SHIFT
    t0 = cyc;
    TokenIn = 1'b1;
    exp_read_q.push_back(t0 + 5);
    goto(t0 + 16);
    chk("t5_pre_reset_hitcount", HitCount, 1);
    chk("t5_pre_reset_freeze", Freeze, 1);
    Reset = 1'b1;
    #1;
    chk("t5_rst_freeze", Freeze, 0);
    chk("t5_rst_read", Read, 0);
    chk("t5_rst_busy", Busy, 0);
    chk("t5_rst_done", FrameDone, 0);
    chk("t5_rst_hitcount", HitCount, 0);
    TokenIn = 1'b0;
    @(posedge ClkOut);
    #1;
    Reset = 1'b0;
    goto(cyc + 2);
    t0 = cyc;
    TokenIn = 1'b1;
    exp_read_q.push_back(t0 + 5);
    exp_read_q.push_back(t0 + 32);
    push_done(t0 + 59, 2, 1'b0);
    goto(t0 + 32);
    TokenIn = 1'b0;
    wait_frames(4, 100);
    goto(cyc + 2);

`ifdef READOUT_WATCHDOG_EN
    // Stuck token is cut off by the frame watchdog
    t0 = cyc;
    TokenIn = 1'b1;
    exp_read_q.push_back(t0 + 5);
    exp_read_q.push_back(t0 + 32);
    exp_read_q.push_back(t0 + 59);
    exp_read_q.push_back(t0 + 86);
    push_done(t0 + 100, 4, 1'b1);
    goto(t0 + 100);
    TokenIn = 1'b0;
    wait_frames(5, 150);
    goto(cyc + 2);
    chk("t6_timeout_cleared", Timeout, 0);
`endif

    chk("read_queue_drained", exp_read_q.size(), 0);
    chk("done_queue_drained", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
